// File: rtl/main_memory_arbiter_if.sv
// main_memory_arbiter_if: client request/ack ports and memory command bundle for main_memory_arbiter
interface main_memory_arbiter_if #(parameter int AWIDTH = 9, parameter int DWIDTH = 8);
  logic req_0, req_1, we_0, we_1;
  logic [AWIDTH-1:0] addr_0, addr_1, addr_mem;
  logic [DWIDTH-1:0] wdata_0, wdata_1, rdata_0, rdata_1, data_in, data_out;
  logic ack_0, ack_1, busy, gnt_id, proto_err, rd_mem, wr_mem, ready_mem;
  modport master(
    input req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, data_out, ready_mem,
    output ack_0, ack_1, rdata_0, rdata_1, busy, gnt_id, proto_err, rd_mem, wr_mem, addr_mem, data_in
  );
  modport slave(
    output req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1, data_out, ready_mem,
    input ack_0, ack_1, rdata_0, rdata_1, busy, gnt_id, proto_err, rd_mem, wr_mem, addr_mem, data_in
  );
endinterface

// File: rtl/main_memory_arbiter.sv
// main_memory_arbiter: two-port round-robin arbiter sequencing one-cycle commands into main_memory
module main_memory_arbiter #(parameter int AWIDTH = 9, parameter int DWIDTH = 8) (
  input logic clk,
  input logic reset,
  main_memory_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, gnt_q, gnt_d, busy_q, busy_d, perr_q, perr_d;
  logic rd_q, rd_d, wr_q, wr_d, ack_0_q, ack_0_d, ack_1_q, ack_1_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdat_q, wdat_d, rdata_0_q, rdata_0_d, rdata_1_q, rdata_1_d;
  logic start, fin, win, we_w;
  always_comb begin
    start = state_q == IDLE && (bus.req_0 || bus.req_1);
    fin = state_q == ISSUE;
    win = (bus.req_0 && bus.req_1) ? ~last_q : bus.req_1;
    we_w = win ? bus.we_1 : bus.we_0;
    state_d = start ? ISSUE : fin ? DONE : IDLE;
    last_d = start ? win : last_q;
    gnt_d = start ? win : gnt_q;
    rd_d = start && !we_w;
    wr_d = start && we_w;
    addr_d = start ? (win ? bus.addr_1 : bus.addr_0) : addr_q;
    wdat_d = start ? (win ? bus.wdata_1 : bus.wdata_0) : wdat_q;
    ack_0_d = fin && !gnt_q;
    ack_1_d = fin && gnt_q;
    // rd_q still marks the command type during ISSUE, so no separate we latch is needed
    rdata_0_d = (fin && rd_q && !gnt_q) ? bus.data_out : rdata_0_q;
    rdata_1_d = (fin && rd_q && gnt_q) ? bus.data_out : rdata_1_q;
    perr_d = perr_q || (fin && bus.ready_mem);
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      gnt_q <= 1'b0;
      busy_q <= 1'b0;
      perr_q <= 1'b0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      ack_0_q <= 1'b0;
      ack_1_q <= 1'b0;
      addr_q <= '0;
      wdat_q <= '0;
      rdata_0_q <= '0;
      rdata_1_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      gnt_q <= gnt_d;
      busy_q <= busy_d;
      perr_q <= perr_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      ack_0_q <= ack_0_d;
      ack_1_q <= ack_1_d;
      addr_q <= addr_d;
      wdat_q <= wdat_d;
      rdata_0_q <= rdata_0_d;
      rdata_1_q <= rdata_1_d;
    end
  end
  assign bus.ack_0 = ack_0_q;
  assign bus.ack_1 = ack_1_q;
  assign bus.rdata_0 = rdata_0_q;
  assign bus.rdata_1 = rdata_1_q;
  assign bus.busy = busy_q;
  assign bus.gnt_id = gnt_q;
  assign bus.proto_err = perr_q;
  assign bus.rd_mem = rd_q;
  assign bus.wr_mem = wr_q;
  assign bus.addr_mem = addr_q;
  assign bus.data_in = wdat_q;
endmodule

// File: tb/tb_main_memory_arbiter.sv
// tb_main_memory_arbiter: directed checks of main_memory_arbiter against a falling-edge memory model
module tb_main_memory_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic force_ready = 1'b0, pl_en = 1'b0;
  logic [8:0] pl_addr = '0;
  logic [7:0] pl_data = '0;
  logic [7:0] mem [512];
  int checks = 0, failures = 0;
  main_memory_arbiter_if #(.AWIDTH(9), .DWIDTH(8)) bus();
  main_memory_arbiter #(.AWIDTH(9), .DWIDTH(8)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.ready_mem = force_ready || !(bus.rd_mem || bus.wr_mem);
  always @(negedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.wr_mem) mem[bus.addr_mem] <= bus.data_in;
    if (bus.rd_mem) bus.data_out <= mem[bus.addr_mem];
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic preload(input logic [8:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    #1;
    pl_en = 1'b0;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    checks++;
    if ({bus.ack_0, bus.ack_1, bus.busy, bus.gnt_id, bus.proto_err, bus.rd_mem, bus.wr_mem} !== 7'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b want=0000000", {bus.ack_0, bus.ack_1, bus.busy, bus.gnt_id, bus.proto_err, bus.rd_mem, bus.wr_mem});
    end
    checks++;
    if ({bus.rdata_0, bus.rdata_1, bus.addr_mem, bus.data_in} !== 33'b0) begin
      failures++; $display("FAIL reset_data got=%h want=0", {bus.rdata_0, bus.rdata_1, bus.addr_mem, bus.data_in});
    end
    reset = 1'b0;
  endtask
  task automatic test_single_read;
    bus.req_0 = 1'b1; bus.we_0 = 1'b0; bus.addr_0 = 9'h010;
    tick;
    checks++;
    if ({bus.rd_mem, bus.wr_mem, bus.busy, bus.gnt_id, bus.addr_mem} !== {4'b1010, 9'h010}) begin
      failures++; $display("FAIL sr_cmd got=%b_%h want=1010_010", {bus.rd_mem, bus.wr_mem, bus.busy, bus.gnt_id}, bus.addr_mem);
    end
    tick;
    checks++;
    if ({bus.ack_0, bus.ack_1, bus.rd_mem, bus.busy, bus.rdata_0} !== {4'b1001, 8'hA5}) begin
      failures++; $display("FAIL sr_ack got=%b_%h want=1001_a5", {bus.ack_0, bus.ack_1, bus.rd_mem, bus.busy}, bus.rdata_0);
    end
    bus.req_0 = 1'b0;
    tick;
    checks++;
    if ({bus.ack_0, bus.ack_1, bus.busy, bus.rd_mem, bus.rdata_0} !== {4'b0000, 8'hA5}) begin
      failures++; $display("FAIL sr_done got=%b_%h want=0000_a5", {bus.ack_0, bus.ack_1, bus.busy, bus.rd_mem}, bus.rdata_0);
    end
    tick;
    checks++;
    if ({bus.busy, bus.rd_mem, bus.ack_0} !== 3'b000) begin
      failures++; $display("FAIL sr_idle got=%b want=000", {bus.busy, bus.rd_mem, bus.ack_0});
    end
  endtask
  task automatic test_write_read;
    bus.req_1 = 1'b1; bus.we_1 = 1'b1; bus.addr_1 = 9'h1FF; bus.wdata_1 = 8'h3C;
    tick;
    checks++;
    if ({bus.wr_mem, bus.rd_mem, bus.gnt_id, bus.addr_mem, bus.data_in} !== {3'b101, 9'h1FF, 8'h3C}) begin
      failures++; $display("FAIL wr_cmd got=%b_%h_%h want=101_1ff_3c", {bus.wr_mem, bus.rd_mem, bus.gnt_id}, bus.addr_mem, bus.data_in);
    end
    tick;
    checks++;
    if ({bus.ack_1, bus.ack_0, bus.wr_mem} !== 3'b100) begin
      failures++; $display("FAIL wr_ack got=%b want=100", {bus.ack_1, bus.ack_0, bus.wr_mem});
    end
    bus.we_1 = 1'b0;
    tick;
    checks++;
    if ({bus.ack_1, bus.rd_mem, bus.wr_mem} !== 3'b000) begin
      failures++; $display("FAIL wr_done got=%b want=000", {bus.ack_1, bus.rd_mem, bus.wr_mem});
    end
    tick;
    checks++;
    if ({bus.rd_mem, bus.wr_mem, bus.gnt_id, bus.addr_mem} !== {3'b101, 9'h1FF}) begin
      failures++; $display("FAIL rb_cmd got=%b_%h want=101_1ff", {bus.rd_mem, bus.wr_mem, bus.gnt_id}, bus.addr_mem);
    end
    tick;
    checks++;
    if ({bus.ack_1, bus.rdata_1, bus.rdata_0} !== {1'b1, 8'h3C, 8'hA5}) begin
      failures++; $display("FAIL rb_ack got=%b_%h_%h want=1_3c_a5", bus.ack_1, bus.rdata_1, bus.rdata_0);
    end
    bus.req_1 = 1'b0;
    tick;
    tick;
  endtask
  task automatic test_contention;
    int n = 0;
    do_reset;
    bus.req_0 = 1'b1; bus.we_0 = 1'b0; bus.addr_0 = 9'h010;
    bus.req_1 = 1'b1; bus.we_1 = 1'b0; bus.addr_1 = 9'h1FF;
    for (int c = 0; c < 12; c++) begin
      tick;
      checks++;
      if ({bus.rd_mem, bus.wr_mem, bus.ack_0, bus.ack_1} !== {c % 3 == 0, 1'b0, c % 6 == 1, c % 6 == 4}) begin
        failures++; $display("FAIL cont_cyc%0d got=%b want=%b", c, {bus.rd_mem, bus.wr_mem, bus.ack_0, bus.ack_1}, {c % 3 == 0, 1'b0, c % 6 == 1, c % 6 == 4});
      end
      if (bus.rd_mem) begin
        checks++;
        if (bus.gnt_id !== 1'((c / 3) % 2)) begin
          failures++; $display("FAIL cont_gnt%0d got=%b want=%b", n, bus.gnt_id, 1'((c / 3) % 2));
        end
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      failures++; $display("FAIL cont_count got=%0d want=4", n);
    end
    bus.req_0 = 1'b0; bus.req_1 = 1'b0;
    tick;
  endtask
  task automatic test_stream;
    bus.req_0 = 1'b1; bus.we_0 = 1'b0; bus.addr_0 = 9'h010;
    for (int c = 0; c < 8; c++) begin
      tick;
      checks++;
      if ({bus.rd_mem, bus.ack_0, bus.ack_1, bus.gnt_id} !== {c % 3 == 0, c % 3 == 1, 2'b00}) begin
        failures++; $display("FAIL stream_cyc%0d got=%b want=%b", c, {bus.rd_mem, bus.ack_0, bus.ack_1, bus.gnt_id}, {c % 3 == 0, c % 3 == 1, 2'b00});
      end
    end
    bus.req_0 = 1'b0;
    tick;
    tick;
    checks++;
    if ({bus.busy, bus.rd_mem, bus.rdata_0} !== {2'b00, 8'hA5}) begin
      failures++; $display("FAIL stream_end got=%b_%h want=00_a5", {bus.busy, bus.rd_mem}, bus.rdata_0);
    end
  endtask
  task automatic test_reset_mid;
    bus.req_0 = 1'b1; bus.we_0 = 1'b1; bus.addr_0 = 9'h005; bus.wdata_0 = 8'h77;
    tick;
    checks++;
    if ({bus.wr_mem, bus.addr_mem, bus.data_in} !== {1'b1, 9'h005, 8'h77}) begin
      failures++; $display("FAIL rm_cmd got=%b_%h_%h want=1_005_77", bus.wr_mem, bus.addr_mem, bus.data_in);
    end
    reset = 1'b1; bus.req_0 = 1'b0;
    tick;
    reset = 1'b0;
    checks++;
    if ({bus.ack_0, bus.ack_1, bus.busy, bus.gnt_id, bus.proto_err, bus.rd_mem, bus.wr_mem, bus.rdata_0, bus.addr_mem, bus.data_in} !== 32'b0) begin
      failures++; $display("FAIL rm_clear got=%b_%h_%h_%h want=0", {bus.ack_0, bus.ack_1, bus.busy, bus.gnt_id, bus.proto_err, bus.rd_mem, bus.wr_mem}, bus.rdata_0, bus.addr_mem, bus.data_in);
    end
    tick;
    checks++;
    if ({bus.ack_0, bus.busy} !== 2'b00) begin
      failures++; $display("FAIL rm_noack got=%b want=00", {bus.ack_0, bus.busy});
    end
    bus.req_0 = 1'b1; bus.we_0 = 1'b0;
    tick;
    tick;
    checks++;
    if ({bus.ack_0, bus.rdata_0} !== {1'b1, 8'h77}) begin
      failures++; $display("FAIL rm_readback got=%b_%h want=1_77", bus.ack_0, bus.rdata_0);
    end
    bus.req_0 = 1'b0;
    tick;
    tick;
  endtask
  task automatic test_ignored;
    bus.req_0 = 1'b1; bus.we_0 = 1'b0; bus.addr_0 = 9'h001; bus.wdata_0 = 8'hEE;
    tick;
    bus.addr_0 = 9'h002; bus.we_0 = 1'b1;
    checks++;
    if ({bus.rd_mem, bus.addr_mem} !== {1'b1, 9'h001}) begin
      failures++; $display("FAIL ign_cmd got=%b_%h want=1_001", bus.rd_mem, bus.addr_mem);
    end
    tick;
    checks++;
    if ({bus.ack_0, bus.rdata_0, bus.addr_mem, bus.wr_mem} !== {1'b1, 8'h11, 9'h001, 1'b0}) begin
      failures++; $display("FAIL ign_data got=%b_%h_%h_%b want=1_11_001_0", bus.ack_0, bus.rdata_0, bus.addr_mem, bus.wr_mem);
    end
    bus.req_0 = 1'b0;
    tick;
    tick;
    checks++;
    if ({mem[2], bus.proto_err} !== {8'h22, 1'b0}) begin
      failures++; $display("FAIL ign_mem_perr got=%h_%b want=22_0", mem[2], bus.proto_err);
    end
  endtask
  task automatic test_proto_err;
    force_ready = 1'b1;
    bus.req_1 = 1'b1; bus.we_1 = 1'b0; bus.addr_1 = 9'h1FF;
    tick;
    checks++;
    if (bus.proto_err !== 1'b0) begin
      failures++; $display("FAIL perr_early got=%b want=0", bus.proto_err);
    end
    tick;
    bus.req_1 = 1'b0; force_ready = 1'b0;
    checks++;
    if ({bus.ack_1, bus.proto_err} !== 2'b11) begin
      failures++; $display("FAIL perr_set got=%b want=11", {bus.ack_1, bus.proto_err});
    end
    tick;
    tick;
    checks++;
    if (bus.proto_err !== 1'b1) begin
      failures++; $display("FAIL perr_sticky got=%b want=1", bus.proto_err);
    end
    do_reset;
    checks++;
    if (bus.proto_err !== 1'b0) begin
      failures++; $display("FAIL perr_reset got=%b want=0", bus.proto_err);
    end
  endtask
  initial begin
    {bus.req_0, bus.req_1, bus.we_0, bus.we_1} = '0;
    {bus.addr_0, bus.addr_1, bus.wdata_0, bus.wdata_1} = '0;
    preload(9'h010, 8'hA5);
    preload(9'h001, 8'h11);
    preload(9'h002, 8'h22);
    test_reset;
    test_single_read;
    test_write_read;
    test_contention;
    test_stream;
    test_reset_mid;
    test_ignored;
    test_proto_err;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/main_memory_arbiter.md
# main_memory_arbiter

Two-port round-robin arbiter and sequencer for the single-port `main_memory` block. Two clients share one memory:
- port 0, typically the instruction fetch path;
- port 1, typically the data / load-store path.

Each client raises a level request. The arbiter picks one client, drives the memory command for exactly one cycle, captures read data and returns a one-cycle acknowledge. All outputs are registered.

## Interface
- `AWIDTH`, 9, address width; matches `main_memory`.
- `DWIDTH`, 8, data width; matches `main_memory`.

Ports:
- `clk`  in  1  single clock. The memory samples on the falling edge; this block uses the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_0`, `req_1`  in  1  access request. Held high until the matching `ack_x` is seen.
- `we_0`, `we_1`  in  1  1 = write, 0 = read. Stable while `req_x` is high.
- `addr_0`, `addr_1`  in  AWIDTH  access address. Stable while `req_x` is high.
- `wdata_0`, `wdata_1`  in  DWIDTH  write data. Stable while `req_x` is high.
- `ack_0`, `ack_1`  out  1  one-cycle completion pulse.
- `rdata_0`, `rdata_1`  out  DWIDTH  read data. Valid with `ack_x` after a read; held until the next read completes on that port.
- `busy`  out  1  high in ISSUE and DONE.
- `gnt_id`  out  1  port currently or last granted.
- `proto_err`  out  1  sticky flag: `ready_mem` was high during ISSUE. Cleared only by reset.
- `rd_mem`, `wr_mem`  out  1  memory command; at most one is high, for one cycle.
- `addr_mem`  out  AWIDTH  memory address.
- `data_in`  out  DWIDTH  memory write data.
- `data_out`  in  DWIDTH  memory read data. Updated on the falling edge of a cycle in which `rd_mem` is high.
- `ready_mem`  in  1  memory ready. Low while `rd_mem` or `wr_mem` is high.

## Operation
States: IDLE, ISSUE, DONE.

- **IDLE**
  - If any `req_x` is high, select a winner, latch its `we`/`addr`/`wdata`, and move to ISSUE.
  - Set `rd_mem` = !we or `wr_mem` = we, `addr_mem` = addr, `data_in` = wdata, `gnt_id` = winner.
  - If neither request is high, stay in IDLE.
- **ISSUE**
  - The memory executes the command on this cycle's falling edge.
  - Move to DONE. Clear `rd_mem`/`wr_mem`.
  - If the command was a read, capture `data_out` into `rdata_<gnt>`.
  - Set `ack_<gnt>` = 1.
  - If `ready_mem` is 1 in this cycle, set `proto_err`.
- **DONE**
  - Clear `ack`. Move to IDLE.
  - `addr_mem`/`data_in` keep their last values; they are don't-care when no command is active.

Arbitration is round-robin on a `last` pointer:
- Only one port requesting: that port wins.
- Both ports requesting: the port != `last` wins.
- `last` updates to the winner at the IDLE→ISSUE transition.
- Reset value of `last` is 1, so port 0 wins the first contention.

Requester rules:
- A requester must drop `req`, or present a new request, at the clock edge ending its `ack` cycle.
- A `req` still high in the IDLE cycle after DONE is treated as a new access.
- A `req` dropped before `ack` is a requester violation. The arbiter still completes the latched access and pulses `ack`.
- Requests are sampled only in IDLE. Changes to `req` or payload during ISSUE or DONE are ignored.

Reset:
- Values after reset: state IDLE; all outputs 0 except `gnt_id` = 0; `last` = 1; `proto_err` = 0.
- Reset asserted while in ISSUE: the memory falling edge of that cycle has already occurred, so a write is committed. The ack is lost, and the requester must reissue.
- Reset asserted while in DONE: the pending ack is dropped.

## Timing
- Request sampled at rising edge E0. The command is visible at the memory during cycle E0–E1.
- `ack_x` is high during E1–E2, with `rdata_x` valid at the same time.
- Latency from request sampled to ack visible: 1 cycle.
- Minimum spacing between command starts: 3 cycles. Peak throughput is one access per 3 cycles.
- Under continuous contention the two ports alternate strictly, giving each port one access per 6 cycles.
- `rd_mem` and `wr_mem` are never high together and never high for more than 1 consecutive cycle.

## Test plan
- **Single read.** Preload mem[0x010] = 0xA5. Pulse reset. Raise `req_0` with `we_0` = 0, `addr_0` = 0x010.
  - Expect `rd_mem` = 1 for exactly 1 cycle with `addr_mem` = 0x010.
  - Next cycle: `ack_0` = 1, `rdata_0` = 0xA5.
  - `ack_1` stays 0.
- **Write then read back.** `req_1` write `addr_1` = 0x1FF, `wdata_1` = 0x3C. After `ack_1`, `req_1` reads 0x1FF.
  - Expect `wr_mem` for 1 cycle with `data_in` = 0x3C.
  - Then `rdata_1` = 0x3C on the second `ack_1`.
- **Contention.** After reset, raise `req_0` and `req_1` in the same cycle; both hold and re-request continuously for 4 accesses.
  - Grant order: 0, 1, 0, 1.
  - Command starts 3 cycles apart.
  - `rd_mem`/`wr_mem` never overlap.
- **Single-requester streaming.** Only `req_0` is held high for 3 accesses.
  - Three back-to-back port-0 accesses, 3 cycles apart. Port 1 is never acked.
- **Reset mid-operation.** Assert reset in the ISSUE cycle of a write of 0x77 to 0x005.
  - Next cycle: all outputs 0, state IDLE, no ack.
  - A later read of 0x005 returns 0x77.
- **Ignored mid-access changes.** Change `addr_0` to 0x002 during ISSUE of a read of 0x001 (mem[0x001] = 0x11, mem[0x002] = 0x22).
  - `rdata_0` = 0x11.
  - `proto_err` remains 0 throughout all tests.
